alu_issue: RTL and testbench

- Operand-issue stage directly upstream of the 48-bit ALU.
- Accepts decoded R-type instructions over a valid/ready handshake and translates funct to the 4-bit ALU control code.
- Drives registered a/b/control into the ALU, tracks the ALU's one-cycle registered latency, and presents writeback tags aligned with the ALU result.
- Forwards the ALU result into dependent operands; stalls one cycle on back-to-back dependences.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_funct_decode.sv | 29 ++
 rtl/alu_issue.sv | 158 +++++++++++++++
 tb/tb_alu_issue.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue path.
// Holds the R-type funct encodings, the 4-bit ALU control codes and the
// default datapath/index widths used by alu_issue and alu_funct_decode.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 48;
  localparam int IDX_W_DEFAULT  = 5;

  typedef logic [5:0] funct_t;
  typedef logic [3:0] alu_code_t;

  // R-type funct field encodings accepted by the issue stage.
  localparam funct_t FUNCT_AND = 6'h24;
  localparam funct_t FUNCT_OR  = 6'h25;
  localparam funct_t FUNCT_ADD = 6'h20;
  localparam funct_t FUNCT_SUB = 6'h22;
  localparam funct_t FUNCT_SLT = 6'h2A;
  localparam funct_t FUNCT_NOR = 6'h27;

  // ALU control codes; ALU_NOP is the bubble the ALU ignores (result held).
  localparam alu_code_t ALU_AND = 4'h0;
  localparam alu_code_t ALU_OR  = 4'h1;
  localparam alu_code_t ALU_ADD = 4'h2;
  localparam alu_code_t ALU_SUB = 4'h6;
  localparam alu_code_t ALU_SLT = 4'h7;
  localparam alu_code_t ALU_NOR = 4'hC;
  localparam alu_code_t ALU_NOP = 4'hF;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational translation of an R-type funct field into
// the ALU control code, plus a flag telling whether the funct is supported.
// Unsupported functs map to the bubble code.
module alu_funct_decode
  import alu_pkg::*;
(
  input  funct_t    funct_i,
  output alu_code_t code_o,
  output logic      legal_o
);

  // Map funct to ALU code; anything unrecognised is a bubble and flagged illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    code_o  = ALU_NOP;
    legal_o = 1'b1;
    unique case (funct_i)
      FUNCT_AND: code_o = ALU_AND;
      FUNCT_OR:  code_o = ALU_OR;
      FUNCT_ADD: code_o = ALU_ADD;
      FUNCT_SUB: code_o = ALU_SUB;
      FUNCT_SLT: code_o = ALU_SLT;
      FUNCT_NOR: code_o = ALU_NOR;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage in front of the 48-bit ALU.
// Accepts decoded R-type instructions (valid/ready), registers operands and
// the ALU control code, tracks the ALU's one-cycle latency to present a
// writeback tag aligned with alu_result, forwards alu_result into dependent
// operands and stalls one cycle when a consumer directly follows its producer.
// Optional feature: define ALU_ISSUE_STALL_CNT_EN to add the saturating
// stall_cnt output counting cycles spent stalled on a hazard.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [IDX_W-1:0]  in_rs_idx,
  input  logic [IDX_W-1:0]  in_rt_idx,
  input  logic [IDX_W-1:0]  in_rd_idx,
  input  logic [0:DATA_W-1] in_rs_val,
  input  logic [0:DATA_W-1] in_rt_val,
  output logic [0:DATA_W-1] alu_a,
  output logic [0:DATA_W-1] alu_b,
  output logic [3:0]        alu_control,
  input  logic [0:DATA_W-1] alu_result,
  output logic              wb_valid,
  output logic [IDX_W-1:0]  wb_rd,
  output logic              illegal
`ifdef ALU_ISSUE_STALL_CNT_EN
  ,
  output logic [0:15]       stall_cnt
`endif
);

  // Operand/control registers driving the ALU, and the s1/wb pipeline tags.
  logic [0:DATA_W-1] alu_a_q, alu_a_d;
  logic [0:DATA_W-1] alu_b_q, alu_b_d;
  alu_code_t         alu_control_q, alu_control_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]  s1_rd_q, s1_rd_d;
  logic              wb_valid_q;
  logic [IDX_W-1:0]  wb_rd_q;
  logic              illegal_q, illegal_d;

  alu_code_t         dec_code;
  logic              dec_legal;
  logic              haz;
  logic              accept;
  logic [0:DATA_W-1] opnd_a;
  logic [0:DATA_W-1] opnd_b;

  alu_funct_decode u_decode (
    .funct_i (in_funct),
    .code_o  (dec_code),
    .legal_o (dec_legal)
  );

  // Hazard: the instruction now on the ALU inputs writes a register this one
  // reads, and its result only appears on alu_result next cycle.
  always_comb begin
    haz      = s1_valid_q && (s1_rd_q != '0) &&
               ((in_rs_idx == s1_rd_q) || (in_rt_idx == s1_rd_q));
    in_ready = !haz;
    accept   = in_valid && !haz;
  end

  // Operand select: r0 reads zero, then forward from the result in writeback,
  // otherwise take the register-file value.
  always_comb begin
    opnd_a = in_rs_val;
    opnd_b = in_rt_val;
    if (in_rs_idx == '0) begin
      opnd_a = '0;
    end else if (wb_valid_q && (in_rs_idx == wb_rd_q)) begin
      opnd_a = alu_result;
    end
    if (in_rt_idx == '0) begin
      opnd_b = '0;
    end else if (wb_valid_q && (in_rt_idx == wb_rd_q)) begin
      opnd_b = alu_result;
    end
  end

  // Next state: a legal accept issues to the ALU; an illegal accept is
  // consumed as a bubble with a one-cycle flag; otherwise issue a bubble and
  // hold the operands so the ALU inputs stay quiet.
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = ALU_NOP;
    s1_valid_d    = 1'b0;
    s1_rd_d       = s1_rd_q;
    illegal_d     = 1'b0;
    if (accept) begin
      if (dec_legal) begin
        alu_a_d       = opnd_a;
        alu_b_d       = opnd_b;
        alu_control_d = dec_code;
        s1_valid_d    = 1'b1;
        s1_rd_d       = in_rd_idx;
      end else begin
        illegal_d     = 1'b1;
      end
    end
  end

  // Pipeline registers; the wb tag follows s1 one cycle behind, matching the
  // ALU's registered latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= ALU_NOP;
      s1_valid_q    <= 1'b0;
      s1_rd_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      illegal_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others (wb takes the old s1, not the new one).
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      s1_valid_q    <= s1_valid_d;
      s1_rd_q       <= s1_rd_d;
      wb_valid_q    <= s1_valid_q;
      wb_rd_q       <= s1_rd_q;
      illegal_q     <= illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign illegal     = illegal_q;

`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [0:15] stall_cnt_q;

  // Count cycles in which a presented instruction is held back by a hazard;
  // sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (in_valid && haz && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue.
// Provides a behavioural registered ALU on alu_result, a table of single-
// instruction vectors, hand-written multi-cycle sequences, and a randomized
// phase checked against an architectural model (register values updated in
// program order at issue, results predicted with plain arithmetic).
module tb_alu_issue;

  localparam int DW = 48;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_funct;
  logic [IW-1:0] in_rs_idx, in_rt_idx, in_rd_idx;
  logic [0:DW-1] in_rs_val, in_rt_val;
  logic [0:DW-1] alu_a, alu_b, alu_result;
  logic [3:0]    alu_control;
  logic          wb_valid;
  logic [IW-1:0] wb_rd;
  logic          illegal;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [0:15]   stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_rs_idx   (in_rs_idx),
    .in_rt_idx   (in_rt_idx),
    .in_rd_idx   (in_rd_idx),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .illegal     (illegal)
`ifdef ALU_ISSUE_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Behavioural ALU: one-cycle registered result, holds on the bubble code.
  function automatic logic [47:0] alu_fn(input logic [3:0] c, input logic [47:0] a, input logic [47:0] b);
    case (c)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return {47'd0, ($signed(a) < $signed(b))};
      4'hC:    return ~(a | b);
      default: return a;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                     alu_result <= '0;
    else if (alu_control != 4'hF) alu_result <= alu_fn(alu_control, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input int rs, input int rt, input int rd,
                       input logic [47:0] rsv, input logic [47:0] rtv);
    in_valid  = v;
    in_funct  = f;
    in_rs_idx = IW'(rs);
    in_rt_idx = IW'(rt);
    in_rd_idx = IW'(rd);
    in_rs_val = rsv;
    in_rt_val = rtv;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model (architectural) ----------------
  function automatic bit ref_legal(input logic [5:0] f);
    return f inside {6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
  endfunction

  function automatic logic [3:0] ref_code(input logic [5:0] f);
    case (f)
      6'h24:   return 4'h0;
      6'h25:   return 4'h1;
      6'h20:   return 4'h2;
      6'h22:   return 4'h6;
      6'h2A:   return 4'h7;
      6'h27:   return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [47:0] ref_op(input logic [5:0] f, input logic [47:0] a, input logic [47:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h20:   return 48'(a + b);
      6'h22:   return 48'(a - b);
      6'h2A:   return (sa < sb) ? 48'd1 : 48'd0;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  typedef struct {
    logic [5:0]  funct;
    logic [47:0] a;
    logic [47:0] b;
    logic [3:0]  code;
    logic        ill;
    logic [47:0] res;
  } vec_t;

  vec_t vecs[9];

  // Architectural state used in the randomized phase.
  logic [47:0] rf   [32];   // register file as seen by the upstream stage
  logic [47:0] arch [32];   // program-order register values
  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [3:0]  code;
    logic [47:0] a, b, res;
  } slot_t;
  slot_t m_s1, m_wb;
  logic  m_ill;
  int    m_stalls;

  initial begin
    logic [5:0]  legal_f [6];
    logic [5:0]  bad_f   [4];
    logic        p_v;
    logic [5:0]  p_f;
    int          p_rs, p_rt, p_rd;
    logic        exp_haz, acc, wv;
    logic [4:0]  wr;
    logic [47:0] wres;

    legal_f = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
    bad_f   = '{6'h00, 6'h3F, 6'h21, 6'h26};

    vecs[0] = '{6'h24, 48'hF0F0, 48'hFF00, 4'h0, 1'b0, 48'hF000};
    vecs[1] = '{6'h25, 48'hF0F0, 48'hFF00, 4'h1, 1'b0, 48'hFFF0};
    vecs[2] = '{6'h20, 48'd5, 48'd7, 4'h2, 1'b0, 48'd12};
    vecs[3] = '{6'h22, 48'd2, 48'd5, 4'h6, 1'b0, 48'hFFFF_FFFF_FFFD};
    vecs[4] = '{6'h2A, 48'hFFFF_FFFF_FFFF, 48'd1, 4'h7, 1'b0, 48'd1};
    vecs[5] = '{6'h2A, 48'd1, 48'hFFFF_FFFF_FFFF, 4'h7, 1'b0, 48'd0};
    vecs[6] = '{6'h27, 48'd0, 48'h0000_0000_FFFF, 4'hC, 1'b0, 48'hFFFF_FFFF_0000};
    vecs[7] = '{6'h3F, 48'd3, 48'd4, 4'hF, 1'b1, 48'd0};
    vecs[8] = '{6'h00, 48'd3, 48'd4, 4'hF, 1'b1, 48'd0};

    // ---- reset values ----
    rst = 1'b1;
    drive(1'b0, 6'h20, 0, 0, 0, 48'd0, 48'd0);
    #12;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_ctl", alu_control, 4'hF);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_illegal", illegal, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // ---- table: funct map, ALU results, illegal pulse ----
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].funct, 1, 2, 7, vecs[i].a, vecs[i].b);
      #1 check($sformatf("vec%0d_ready", i), in_ready, 1);
      tick();
      idle();
      check($sformatf("vec%0d_ctl", i), alu_control, vecs[i].code);
      check($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      if (!vecs[i].ill) begin
        check($sformatf("vec%0d_a", i), alu_a, vecs[i].a);
        check($sformatf("vec%0d_b", i), alu_b, vecs[i].b);
      end
      tick();
      check($sformatf("vec%0d_wb_valid", i), wb_valid, !vecs[i].ill);
      check($sformatf("vec%0d_illegal_off", i), illegal, 0);
      if (!vecs[i].ill) begin
        check($sformatf("vec%0d_wb_rd", i), wb_rd, 7);
        check($sformatf("vec%0d_res", i), alu_result, vecs[i].res);
      end
    end

    // ---- reset asserted mid-cycle with an instruction in flight ----
    drive(1'b1, 6'h20, 1, 2, 3, 48'd5, 48'd7);
    tick();
    idle();
    in_rs_idx = 5'd3;
    in_rt_idx = 5'd3;
    check("mid_pre_ctl", alu_control, 4'h2);
    #2 rst = 1'b1;
    #1;
    check("mid_alu_a", alu_a, 0);
    check("mid_alu_b", alu_b, 0);
    check("mid_ctl", alu_control, 4'hF);
    check("mid_wb_rd", wb_rd, 0);
    check("mid_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_post_wb_valid", wb_valid, 0);
    check("mid_post_ctl", alu_control, 4'hF);

    // ---- independent back-to-back issue ----
    drive(1'b1, 6'h20, 1, 2, 3, 48'd5, 48'd7);
    #1 check("ind_ready0", in_ready, 1);
    tick();
    drive(1'b1, 6'h25, 5, 6, 4, 48'h30, 48'h0C);
    #1 check("ind_ready1", in_ready, 1);
    check("ind_ctl0", alu_control, 4'h2);
    tick();
    idle();
    check("ind_ctl1", alu_control, 4'h1);
    check("ind_wb0_valid", wb_valid, 1);
    check("ind_wb0_rd", wb_rd, 3);
    check("ind_wb0_res", alu_result, 12);
    tick();
    check("ind_wb1_valid", wb_valid, 1);
    check("ind_wb1_rd", wb_rd, 4);
    check("ind_wb1_res", alu_result, 48'h3C);

    // ---- back-to-back dependence: one stall then forward ----
    drive(1'b1, 6'h20, 1, 2, 3, 48'd5, 48'd7);
    tick();
    drive(1'b1, 6'h22, 3, 1, 4, 48'hDEAD, 48'd2);
    #1 check("dep_stall", in_ready, 0);
    tick();
    #1 check("dep_release", in_ready, 1);
    check("dep_stall_ctl", alu_control, 4'hF);
    check("dep_wb_rd", wb_rd, 3);
    tick();
    idle();
    check("dep_ctl", alu_control, 4'h6);
    check("dep_fwd_a", alu_a, 12);
    check("dep_b", alu_b, 2);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("dep_stall_cnt", stall_cnt, 1);
`endif
    tick();
    check("dep_wb_valid", wb_valid, 1);
    check("dep_wb_rd2", wb_rd, 4);
    check("dep_res", alu_result, 10);

    // ---- dependence two cycles apart: no stall, both operands forwarded ----
    drive(1'b1, 6'h20, 1, 2, 3, 48'd5, 48'd7);
    tick();
    idle();
    tick();
    drive(1'b1, 6'h24, 3, 3, 5, 48'h111, 48'h222);
    #1 check("gap_ready", in_ready, 1);
    tick();
    idle();
    check("gap_fwd_a", alu_a, 12);
    check("gap_fwd_b", alu_b, 12);
    tick();
    check("gap_wb_rd", wb_rd, 5);
    check("gap_res", alu_result, 12);

    // ---- rd=0 producer then consumer of r0 ----
    drive(1'b1, 6'h20, 1, 2, 0, 48'd5, 48'd7);
    tick();
    drive(1'b1, 6'h25, 0, 0, 6, 48'h55, 48'h66);
    #1 check("r0_ready", in_ready, 1);
    tick();
    idle();
    tick();
    drive(1'b1, 6'h25, 0, 0, 6, 48'h55, 48'h66);
    #1 check("r0_ready_wb", in_ready, 1);
    tick();
    idle();
    check("r0_a", alu_a, 0);
    check("r0_b", alu_b, 0);
    check("r0_ctl", alu_control, 4'h1);

    // ---- randomized phase against the architectural model ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      arch[r] = (r == 0) ? 48'd0 : rand48();
      rf[r]   = (r == 0) ? 48'hBAD0_0000_BAD0 : arch[r];
    end
    m_s1     = '{v: 1'b0, rd: '0, code: 4'hF, a: '0, b: '0, res: '0};
    m_wb     = m_s1;
    m_ill    = 1'b0;
    m_stalls = 0;
    p_v  = 1'b0;
    p_f  = 6'h20;
    p_rs = 0;
    p_rt = 0;
    p_rd = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!p_v) begin
        p_v  = ($urandom_range(0, 3) != 0);
        p_f  = ($urandom_range(0, 9) == 0) ? bad_f[$urandom_range(0, 3)] : legal_f[$urandom_range(0, 5)];
        p_rs = $urandom_range(0, 7);
        p_rt = $urandom_range(0, 7);
        p_rd = $urandom_range(0, 7);
      end
      drive(p_v, p_f, p_rs, p_rt, p_rd, rf[p_rs], rf[p_rt]);
      #1;
      exp_haz = m_s1.v && (m_s1.rd != 0) && (p_rs == int'(m_s1.rd) || p_rt == int'(m_s1.rd));
      check("rnd_ready", in_ready, !exp_haz);
      if (p_v && exp_haz) m_stalls++;
      acc  = p_v && !exp_haz;
      wv   = wb_valid;
      wr   = wb_rd;
      wres = alu_result;
      @(posedge clk);
      if (wv && wr != 0) rf[wr] = wres;
      m_wb  = m_s1;
      m_ill = acc && !ref_legal(p_f);
      m_s1.v = 1'b0;
      if (acc && ref_legal(p_f)) begin
        m_s1.v    = 1'b1;
        m_s1.rd   = 5'(p_rd);
        m_s1.code = ref_code(p_f);
        m_s1.a    = arch[p_rs];
        m_s1.b    = arch[p_rt];
        m_s1.res  = ref_op(p_f, arch[p_rs], arch[p_rt]);
        if (p_rd != 0) arch[p_rd] = m_s1.res;
      end
      if (acc) p_v = 1'b0;
      @(negedge clk);
      check("rnd_wb_valid", wb_valid, m_wb.v);
      if (m_wb.v) begin
        check("rnd_wb_rd", wb_rd, m_wb.rd);
        check("rnd_wb_res", alu_result, m_wb.res);
      end
      check("rnd_ctl", alu_control, m_s1.v ? m_s1.code : 4'hF);
      if (m_s1.v) begin
        check("rnd_a", alu_a, m_s1.a);
        check("rnd_b", alu_b, m_s1.b);
      end
      check("rnd_illegal", illegal, m_ill);
    end
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("rnd_stall_cnt", stall_cnt, m_stalls);
`endif

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
